trigger_sequencer: RTL
======================

# trigger_sequencer

Arm/qualify/delay/pulse controller that sits between the digital edge detector and the external trigger pin, sequencing when a detected edge becomes a glitch/capture trigger. It counts N qualifying edges after arming, waits a programmable delay, drives a pulse of programmable width, then either stops or re-arms. It runs entirely in the sampling clock domain. Configuration arrives as quasi-static words from the register block.

## Interface
Parameters:
- `EDGE_W`, default 8: width of the edge-count configuration.
- `DELAY_W`, default 32: width of the delay configuration and counter.
- `PULSE_W`, default 16: width of the pulse-width configuration and counter.

Ports:
- `sampleclk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: one-cycle request to start a sequence.
- `abort` in 1: one-cycle request to cancel any sequence.
- `edge_in` in 1: edge-detector event; each high cycle is one edge.
- `cfg_edges` in EDGE_W: number of edges required; 0 is treated as 1.
- `cfg_delay` in DELAY_W: cycles between the qualifying edge and the pulse.
- `cfg_width` in PULSE_W: pulse length in cycles; 0 is treated as 1.
- `cfg_rearm` in 1: when 1, the block returns to ARMED after each pulse instead of DONE.
- `trig_out` out 1: trigger pulse.
- `armed` out 1: high while in ARMED.
- `busy` out 1: high in ARMED, DELAY or PULSE.
- `done` out 1: high in DONE.
- `fire_count` out 16: total pulses issued since reset; saturates at 16'hFFFF.

## Operation
States: IDLE, ARMED, DELAY, PULSE, DONE. All outputs are registered.

Reset values:
- State is IDLE.
- `trig_out`, `armed`, `busy`, `done` are 0.
- `fire_count` is 0. The internal edge, delay and width counters are 0.

Arming:
- `arm` in IDLE or DONE moves to ARMED on the next cycle.
- On that transition, `cfg_edges`, `cfg_delay`, `cfg_width` and `cfg_rearm` are latched into shadow registers, and the edge counter is cleared.
- Changes to the `cfg_*` inputs while busy have no effect until the next arm.
- `arm` in ARMED, DELAY or PULSE is ignored.

ARMED:
- Each `edge_in` high cycle increments the edge counter.
- On the cycle where `edge_in` is high and counter+1 equals N (N = max(latched edges, 1)), the state moves to DELAY if the latched delay is non-zero, otherwise to PULSE.
- `edge_in` is ignored in every state other than ARMED.

DELAY:
- The state lasts exactly D cycles (D = latched delay), then moves to PULSE.
- The counter has DELAY_W bits; D = 2^DELAY_W−1 is legal and must not wrap early.

PULSE:
- `trig_out` is 1 for exactly W cycles (W = max(latched width, 1)).
- On the last pulse cycle, `fire_count` increments (saturating).
- The next state is ARMED if latched `cfg_rearm` = 1 (edge counter cleared, shadow config retained), otherwise DONE.

DONE:
- The state holds until `arm` (go to ARMED) or `abort` (go to IDLE).

Abort:
- `abort` in any state moves to IDLE on the next cycle and clears `trig_out`, which may truncate a pulse.
- A truncated pulse does not increment `fire_count`.
- `abort` and `arm` in the same cycle: `abort` wins.

`reset` mid-sequence returns every output to its reset value on the next cycle, including `fire_count`.

## Timing
- `arm` sampled at cycle a: `armed` = `busy` = 1 at cycle a+1. An `edge_in` at a+1 counts.
- Qualifying `edge_in` sampled at cycle t: `trig_out` rises at cycle t+1+D and falls at cycle t+1+D+W.
- For D = 0, `trig_out` rises at t+1.
- `fire_count` shows the new value at cycle t+1+D+W.
- At that same cycle, either `done` = 1 or `armed` = 1 (re-arm). With re-arm, an edge at t+1+D+W counts toward the next sequence.
- `abort` sampled at cycle c: `trig_out` = `busy` = `armed` = 0 at cycle c+1.
- Throughput with re-arm: minimum edge-to-edge spacing for consecutive triggers is 1+D+W cycles. Edges arriving in DELAY or PULSE are dropped, not queued.

## Test plan
- Basic: `cfg_edges`=1, `cfg_delay`=0, `cfg_width`=1, arm, then `edge_in` at t → `trig_out` high only at t+1. `done`=1 from t+2. `fire_count`=1.
- Count and delay: `cfg_edges`=3, `cfg_delay`=5, `cfg_width`=4, edges at t, t+2, t+7 → `trig_out` high for cycles t+13..t+16. The first two edges produce no pulse.
- Zero-config aliasing: `cfg_edges`=0, `cfg_width`=0 → behaves exactly as `cfg_edges`=1, `cfg_width`=1.
- Re-arm: `cfg_rearm`=1, `cfg_delay`=2, `cfg_width`=2, edges at t and t+3 → `trig_out` at t+3..t+4. The edge at t+3 is dropped, so a further edge at t+5 is needed for the next pulse, at t+8..t+9. `fire_count`=2.
- Abort mid-pulse: `cfg_width`=10, `abort` on the 3rd pulse cycle → `trig_out` low next cycle, state IDLE, `fire_count` unchanged. `arm` and `abort` together → IDLE.
- Config isolation: change the `cfg_*` inputs while in DELAY → the current pulse timing is unchanged. The new values take effect only after the next `arm`. `reset` while in PULSE → all outputs 0 next cycle.

Source files
------------

// File: rtl/trigger_sequencer.sv
// Arm/qualify/delay/pulse trigger controller: counts qualifying edges after arming,
// waits a programmable delay, drives a pulse of programmable width, then stops or re-arms.
module trigger_sequencer #(
  parameter int EDGE_W  = 8,
  parameter int DELAY_W = 32,
  parameter int PULSE_W = 16
) (
  input  logic               sampleclk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               edge_in,
  input  logic [EDGE_W-1:0]  cfg_edges,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [PULSE_W-1:0] cfg_width,
  input  logic               cfg_rearm,
  output logic               trig_out,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [15:0]        fire_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [PULSE_W-1:0] wid_cnt_q, wid_cnt_d;
  logic [EDGE_W-1:0]  sh_edges_q, sh_edges_d;
  logic [DELAY_W-1:0] sh_delay_q, sh_delay_d;
  logic [PULSE_W-1:0] sh_width_q, sh_width_d;
  logic               sh_rearm_q, sh_rearm_d;
  logic [15:0]        fire_cnt_q, fire_cnt_d;
  logic               trig_q, trig_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [EDGE_W:0]    edge_inc;
  logic               load_cfg;

  // One bit wider so the compare against the edge target can never wrap.
  assign edge_inc = {1'b0, edge_cnt_q} + (EDGE_W+1)'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      dly_cnt_q  <= '0;
      wid_cnt_q  <= '0;
      sh_edges_q <= '0;
      sh_delay_q <= '0;
      sh_width_q <= '0;
      sh_rearm_q <= 1'b0;
      fire_cnt_q <= '0;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      wid_cnt_q  <= wid_cnt_d;
      sh_edges_q <= sh_edges_d;
      sh_delay_q <= sh_delay_d;
      sh_width_q <= sh_width_d;
      sh_rearm_q <= sh_rearm_d;
      fire_cnt_q <= fire_cnt_d;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    wid_cnt_d  = wid_cnt_q;
    fire_cnt_d = fire_cnt_q;
    load_cfg   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d  = S_ARMED;
            load_cfg = 1'b1;
          end
        end
        S_ARMED: begin
          if (edge_in) begin
            edge_cnt_d = edge_inc[EDGE_W-1:0];
            if (edge_inc == {1'b0, sh_edges_q}) begin
              if (sh_delay_q != '0) begin
                state_d   = S_DELAY;
                dly_cnt_d = sh_delay_q;
              end else begin
                state_d   = S_PULSE;
                wid_cnt_d = sh_width_q;
              end
            end
          end
        end
        S_DELAY: begin
          // Down-count from D so the full DELAY_W range is usable without wrap.
          dly_cnt_d = dly_cnt_q - DELAY_W'(1);
          if (dly_cnt_q == DELAY_W'(1)) begin
            state_d   = S_PULSE;
            wid_cnt_d = sh_width_q;
          end
        end
        S_PULSE: begin
          wid_cnt_d = wid_cnt_q - PULSE_W'(1);
          if (wid_cnt_q == PULSE_W'(1)) begin
            if (fire_cnt_q != 16'hFFFF) fire_cnt_d = fire_cnt_q + 16'd1;
            if (sh_rearm_q) begin
              state_d    = S_ARMED;
              edge_cnt_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Zero edge/width configurations alias to one, folded in at capture time.
    sh_edges_d = sh_edges_q;
    sh_delay_d = sh_delay_q;
    sh_width_d = sh_width_q;
    sh_rearm_d = sh_rearm_q;
    if (load_cfg) begin
      sh_edges_d = (cfg_edges == '0) ? EDGE_W'(1) : cfg_edges;
      sh_delay_d = cfg_delay;
      sh_width_d = (cfg_width == '0) ? PULSE_W'(1) : cfg_width;
      sh_rearm_d = cfg_rearm;
      edge_cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    trig_d  = (state_d == S_PULSE);
    armed_d = (state_d == S_ARMED);
    busy_d  = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_PULSE);
    done_d  = (state_d == S_DONE);
  end

  assign trig_out   = trig_q;
  assign armed      = armed_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fire_count = fire_cnt_q;

endmodule
